// File: rtl/piece_move_sched.sv
// Per-frame scheduler for the falling tetromino: arbitrates key moves and gravity,
// validates each candidate with the board checker, then locks and respawns pieces.
module piece_move_sched #(
    parameter int BOARD_W     = 10,
    parameter int BOARD_H     = 20,
    parameter int SPAWN_X     = 4,
    parameter int GRAV_FRAMES = 16,
    parameter int SOFT_FRAMES = 2,
    parameter int DAS_FRAMES  = 10,
    parameter int ARR_FRAMES  = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic       chk_req,
    output logic [3:0] chk_x,
    output logic [4:0] chk_y,
    output logic [1:0] chk_rot,
    input  logic       chk_ack,
    input  logic       chk_hit,
    output logic       lock_req,
    input  logic       lock_ack,
    output logic [3:0] piece_x,
    output logic [4:0] piece_y,
    output logic [1:0] piece_rot,
    output logic       piece_valid,
    output logic       game_over
);
    localparam logic [7:0] KEY_W      = 8'h1a;
    localparam logic [7:0] KEY_A      = 8'h04;
    localparam logic [7:0] KEY_S      = 8'h16;
    localparam logic [7:0] KEY_D      = 8'h07;
    localparam logic [3:0] X_MAX      = 4'(BOARD_W - 1);
    localparam logic [4:0] Y_MAX      = 5'(BOARD_H - 1);
    localparam logic [3:0] X_SPAWN    = 4'(SPAWN_X);
    localparam logic [7:0] GRAV_LIM   = 8'(GRAV_FRAMES);
    localparam logic [7:0] SOFT_LIM   = 8'(SOFT_FRAMES);
    localparam logic [7:0] DAS_LIM    = 8'(DAS_FRAMES);
    localparam logic [7:0] ARR_RELOAD = 8'(DAS_FRAMES - ARR_FRAMES);

    typedef enum logic [2:0] {IDLE, KCHK, GCHK, WAIT, LOCK, SPAWN, DEAD} state_t;
    typedef enum logic [1:0] {K_KEY, K_GRAV, K_SPAWN} kind_t;

    state_t     state;
    kind_t      kind;
    logic [2:0] fc_pipe;
    logic [7:0] grav_cnt, rep_cnt, last_key, mv_key;
    logic       grav_pend;

    // Two sync flops plus one history flop for rising-edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) fc_pipe <= '0;
        else          fc_pipe <= {fc_pipe[1:0], frame_clk};
    end

    logic       tick, tick_ok, new_key, is_ad, rep_fire, grav_due, key_due;
    logic [7:0] grav_nxt, rep_nxt;

    assign tick     = fc_pipe[1] & ~fc_pipe[2];
    assign tick_ok  = tick && (state == IDLE) && !chk_ack;
    assign grav_nxt = grav_cnt + 8'd1;
    assign grav_due = grav_nxt >= ((keycode == KEY_S) ? SOFT_LIM : GRAV_LIM);
    assign new_key  = keycode != last_key;
    assign is_ad    = (keycode == KEY_A) || (keycode == KEY_D);
    assign rep_nxt  = rep_cnt + 8'd1;
    // After the DAS delay the counter reloads so it re-fires every ARR ticks.
    assign rep_fire = !new_key && (rep_nxt == DAS_LIM);
    assign key_due  = new_key ? (is_ad || keycode == KEY_W) : (rep_fire && is_ad);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= SPAWN;
            kind        <= K_SPAWN;
            grav_cnt    <= '0;
            rep_cnt     <= '0;
            last_key    <= '0;
            mv_key      <= '0;
            grav_pend   <= 1'b0;
            chk_req     <= 1'b0;
            chk_x       <= '0;
            chk_y       <= '0;
            chk_rot     <= '0;
            lock_req    <= 1'b0;
            piece_x     <= X_SPAWN;
            piece_y     <= '0;
            piece_rot   <= '0;
            piece_valid <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            if (tick_ok) begin
                grav_cnt <= grav_due ? 8'd0 : grav_nxt;
                rep_cnt  <= new_key ? 8'd0 : (rep_fire ? ARR_RELOAD : rep_nxt);
                last_key <= keycode;
            end
            case (state)
                IDLE: if (tick_ok) begin
                    mv_key    <= keycode;
                    grav_pend <= grav_due;
                    if (key_due)       state <= KCHK;
                    else if (grav_due) state <= GCHK;
                end
                KCHK: begin
                    if ((mv_key == KEY_A && piece_x == 4'd0) ||
                        (mv_key == KEY_D && piece_x == X_MAX)) begin
                        state <= grav_pend ? GCHK : IDLE;
                    end else begin
                        chk_req <= 1'b1;
                        chk_x   <= piece_x;
                        chk_y   <= piece_y;
                        chk_rot <= piece_rot;
                        if (mv_key == KEY_A)      chk_x   <= piece_x - 4'd1;
                        else if (mv_key == KEY_D) chk_x   <= piece_x + 4'd1;
                        else                      chk_rot <= piece_rot + 2'd1;
                        kind  <= K_KEY;
                        state <= WAIT;
                    end
                end
                GCHK: begin
                    grav_pend <= 1'b0;
                    if (piece_y == Y_MAX) begin
                        lock_req <= 1'b1;
                        state    <= LOCK;
                    end else begin
                        chk_req <= 1'b1;
                        chk_x   <= piece_x;
                        chk_y   <= piece_y + 5'd1;
                        chk_rot <= piece_rot;
                        kind    <= K_GRAV;
                        state   <= WAIT;
                    end
                end
                WAIT: if (chk_ack) begin
                    chk_req <= 1'b0;
                    if (!chk_hit) begin
                        piece_x   <= chk_x;
                        piece_y   <= chk_y;
                        piece_rot <= chk_rot;
                    end
                    case (kind)
                        K_KEY:  state <= grav_pend ? GCHK : IDLE;
                        K_GRAV: if (chk_hit) begin
                            lock_req <= 1'b1;
                            state    <= LOCK;
                        end else begin
                            state <= IDLE;
                        end
                        default: if (chk_hit) begin
                            game_over <= 1'b1;
                            state     <= DEAD;
                        end else begin
                            piece_valid <= 1'b1;
                            state       <= IDLE;
                        end
                    endcase
                end
                LOCK: if (lock_ack) begin
                    lock_req    <= 1'b0;
                    piece_valid <= 1'b0;
                    state       <= SPAWN;
                end
                SPAWN: begin
                    chk_req <= 1'b1;
                    chk_x   <= X_SPAWN;
                    chk_y   <= '0;
                    chk_rot <= '0;
                    kind    <= K_SPAWN;
                    state   <= WAIT;
                end
                DEAD:    state <= DEAD;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piece_move_sched.sv
// Randomized bench for piece_move_sched: a per-tick game model predicts every
// checker/lock request and the committed piece after each frame.
module tb_piece_move_sched;
    localparam logic [7:0] KW = 8'h1a, KA = 8'h04, KS = 8'h16, KD = 8'h07;
    localparam int DAS = 10, ARR = 3;

    logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       chk_ack = 1'b0, chk_hit = 1'b0, lock_ack = 1'b0;
    logic       chk_req, lock_req, piece_valid, game_over;
    logic [3:0] chk_x, piece_x;
    logic [4:0] chk_y, piece_y;
    logic [1:0] chk_rot, piece_rot;

    piece_move_sched dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_rot(chk_rot),
        .chk_ack(chk_ack), .chk_hit(chk_hit), .lock_req(lock_req), .lock_ack(lock_ack),
        .piece_x(piece_x), .piece_y(piece_y), .piece_rot(piece_rot),
        .piece_valid(piece_valid), .game_over(game_over)
    );

    always #10 Clk = ~Clk;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    int mx, my, mrot, gcnt, h, n_lock;
    bit mvalid, mdead;
    logic [7:0] last_key;
    int p_key, p_grav, p_spawn, p_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit roll(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic quiet(input int n);
        bit seen = 0;
        repeat (n) begin
            @(negedge Clk);
            if (chk_req || lock_req) seen = 1;
        end
        check("quiet", 32'(seen), 32'd0);
    endtask

    task automatic cmp_piece(input string tag);
        check(tag, 32'({game_over, piece_valid, piece_rot, piece_y, piece_x}),
              32'({mdead, mvalid, 2'(mrot), 5'(my), 4'(mx)}));
    endtask

    task automatic service_chk(input string tag, input int x, input int y, input int r, input bit hit);
        int n = 0;
        while (!chk_req && n < 50) begin @(negedge Clk); n++; end
        check({tag, "_req"}, 32'(chk_req), 32'd1);
        check({tag, "_cand"}, 32'({chk_x, chk_y, chk_rot}), 32'({4'(x), 5'(y), 2'(r)}));
        if (chk_req && roll(p_drop)) begin
            // a frame edge landing mid-handshake must be ignored
            frame_clk = 1'b1; repeat (3) @(negedge Clk); frame_clk = 1'b0;
            repeat (5) @(negedge Clk);
            check({tag, "_hold"}, 32'({chk_req, chk_x, chk_y, chk_rot}),
                  32'({1'b1, 4'(x), 5'(y), 2'(r)}));
        end
        chk_ack = 1'b1; chk_hit = hit;
        @(negedge Clk);
        chk_ack = 1'b0; chk_hit = 1'b0;
    endtask

    task automatic spawn(input bit hit);
        service_chk("spawn", 4, 0, 0, hit);
        if (hit) begin mdead = 1; mvalid = 0; end
        else begin mx = 4; my = 0; mrot = 0; mvalid = 1; end
    endtask

    task automatic lock_spawn();
        int n = 0;
        while (!lock_req && n < 50) begin @(negedge Clk); n++; end
        check("lock_req", 32'(lock_req), 32'd1);
        check("lock_valid", 32'(piece_valid), 32'd1);
        lock_ack = 1'b1;
        @(negedge Clk);
        lock_ack = 1'b0;
        check("lock_drop", 32'({lock_req, piece_valid}), 32'd0);
        n_lock++;
        spawn(roll(p_spawn));
    endtask

    task automatic do_reset(input bit hit, input bit lat);
        int t0;
        Reset_n = 1'b0;
        #1;
        check("rst_out", 32'({chk_req, lock_req, piece_valid, game_over, piece_rot, piece_y, piece_x}),
              32'({4'b0000, 2'd0, 5'd0, 4'd4}));
        @(negedge Clk);
        keycode = 8'h00;
        Reset_n = 1'b1;
        t0 = cyc;
        mx = 4; my = 0; mrot = 0; mvalid = 0; mdead = 0; gcnt = 0; h = 0; last_key = 8'h00;
        spawn(hit);
        if (lat) check("spawn_lat", 32'(piece_valid && (cyc - t0) <= 4), 32'd1);
        quiet(3);
        cmp_piece("rst_piece");
    endtask

    // Model: one frame of game rules, driving the checker/lock handshakes it predicts.
    task automatic run_tick(input logic [7:0] key);
        bit kdue, gdue, hit;
        int cx, cr;
        keycode = key;
        frame_clk = 1'b1; repeat (4) @(negedge Clk); frame_clk = 1'b0;
        if (!mdead) begin
            h = (key == last_key) ? h + 1 : 0;
            if (key != last_key) kdue = (key == KW || key == KA || key == KD);
            else kdue = (key == KA || key == KD) && (h == DAS || (h > DAS && (h - DAS) % ARR == 0));
            last_key = key;
            gcnt++;
            gdue = gcnt >= ((key == KS) ? 2 : 16);
            if (gdue) gcnt = 0;
            if (kdue && !((key == KA && mx == 0) || (key == KD && mx == 9))) begin
                cx = mx + ((key == KA) ? -1 : (key == KD) ? 1 : 0);
                cr = (key == KW) ? (mrot + 1) % 4 : mrot;
                hit = roll(p_key);
                service_chk("key", cx, my, cr, hit);
                if (!hit) begin mx = cx; mrot = cr; end
            end
            if (gdue) begin
                if (my == 19) lock_spawn();
                else begin
                    hit = roll(p_grav);
                    service_chk("grav", mx, my + 1, mrot, hit);
                    if (!hit) my++;
                    else lock_spawn();
                end
            end
        end
        quiet(6);
        cmp_piece("piece");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] keys [6];
        logic [7:0] key;
        int locks0;
        keys = '{8'h00, KA, KD, KW, KS, 8'h55};
        p_key = 0; p_grav = 0; p_spawn = 0; p_drop = 0; n_lock = 0;
        repeat (3) @(negedge Clk);
        do_reset(1'b0, 1'b1);

        repeat (16) run_tick(8'h00);
        check("grav_y1", 32'(piece_y), 32'd1);

        repeat (3) begin run_tick(KA); run_tick(8'h00); end
        check("x_at_1", 32'(piece_x), 32'd1);
        repeat (16) run_tick(KA);
        check("x_wall_l", 32'(piece_x), 32'd0);
        repeat (12) begin run_tick(KD); run_tick(8'h00); end
        check("x_wall_r", 32'(piece_x), 32'd9);

        repeat (3) begin run_tick(KW); run_tick(8'h00); end
        check("rot3", 32'(piece_rot), 32'd3);
        while (gcnt != 15) run_tick(8'h00);
        run_tick(KW);
        check("rot_wrap", 32'(piece_rot), 32'd0);

        locks0 = n_lock;
        p_grav = 100;
        run_tick(KS); run_tick(KS);
        check("grav_lock", 32'(n_lock - locks0), 32'd1);
        p_grav = 0;
        repeat (45) run_tick(KS);
        check("floor_lock", 32'(n_lock - locks0), 32'd2);

        do_reset(1'b1, 1'b0);
        run_tick(KA);
        check("dead_sticky", 32'(game_over), 32'd1);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        check("mid_wait_req", 32'(chk_req), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("mid_wait_rst", 32'({chk_req, game_over}), 32'd0);
        do_reset(1'b0, 1'b0);

        p_key = 20; p_grav = 12; p_spawn = 4; p_drop = 8;
        key = 8'h00;
        repeat (300) begin
            if (roll(25)) key = keys[$urandom_range(0, 5)];
            run_tick(key);
            if (mdead) do_reset(1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
